// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch burst generator.
//   state_e       : FSM state encoding (3 bits)
//   CNT_W_DEF     : default width of delay/width/gap counters
//   NPULSE_W_DEF  : default width of pulse count / pulse index
//   is_busy()     : true for the states in which a burst is in progress
package glitch_pkg;

    localparam int CNT_W_DEF    = 32;
    localparam int NPULSE_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_PULSE = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == S_DELAY) || (s == S_PULSE) || (s == S_GAP);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser with rising-edge detector for an asynchronous input.
//   clk      : destination clock
//   rst_n    : asynchronous active-low reset
//   d_async  : asynchronous input
//   q_sync   : synchronised level (STAGES flops deep)
//   rise     : one-cycle pulse in the first cycle q_sync is high after being low
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic q_sync,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_async};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q_sync = sync_q[STAGES-1];
    // prev tracks the level every cycle, so a level that is already high
    // when the caller starts listening never produces a rise.
    assign rise   = q_sync & ~prev_q;

endmodule

// File: rtl/glitch_burst_gen.sv
// Glitch burst generator. After an armed, synchronised trigger rising edge it
// waits delay_cycles, then emits max(pulse_count,1) pulses of max(width,1)
// cycles separated by max(gap,1) idle cycles.
//   clk, rst_n     : core clock, asynchronous active-low reset
//   arm            : in IDLE, latch config and enter ARMED
//   abort          : synchronous, highest priority, return to IDLE
//   trigger        : asynchronous trigger, rising edge fires
//   delay_cycles, width_cycles, gap_cycles, pulse_count : burst config
//   glitch         : registered glitch output (GLITCH_ACTIVE when pulsing)
//   armed, delay_active, busy, done : registered state flags
//   pulse_idx      : 0-based index of current/last pulse
module glitch_burst_gen
    import glitch_pkg::*;
#(
    parameter int   CNT_W         = CNT_W_DEF,
    parameter int   NPULSE_W      = NPULSE_W_DEF,
    parameter int   SYNC_STAGES   = 2,
    parameter logic GLITCH_ACTIVE = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic                abort,
    input  logic                trigger,
    input  logic [CNT_W-1:0]    delay_cycles,
    input  logic [CNT_W-1:0]    width_cycles,
    input  logic [CNT_W-1:0]    gap_cycles,
    input  logic [NPULSE_W-1:0] pulse_count,
    output logic                glitch,
    output logic                armed,
    output logic                delay_active,
    output logic                busy,
    output logic                done,
    output logic [NPULSE_W-1:0] pulse_idx
);

    localparam logic [CNT_W-1:0]    CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NPULSE_W-1:0] NP_ONE  = {{(NPULSE_W-1){1'b0}}, 1'b1};

    // max(v,1)-1 : zero-valued width/gap behave as one cycle
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_ONE;
    endfunction

    // ---------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on a clock edge
    // ---------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_int_n = rst_sync_q[1];

    // ---------------------------------------------------------------------
    // Trigger synchroniser / edge detector
    // ---------------------------------------------------------------------
    logic trig_sync, trig_rise;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_trig_sync (
        .clk     (clk),
        .rst_n   (rst_int_n),
        .d_async (trigger),
        .q_sync  (trig_sync),
        .rise    (trig_rise)
    );

    // ---------------------------------------------------------------------
    // State, shared down-counter, pulse index, shadow config
    // ---------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NPULSE_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]      delay_s_q, delay_s_d;
    logic [CNT_W-1:0]      width_s_q, width_s_d;
    logic [CNT_W-1:0]      gap_s_q, gap_s_d;
    logic [NPULSE_W-1:0]   last_s_q, last_s_d;    // max(count,1)-1

    logic                  glitch_q, glitch_d;
    logic                  armed_q, armed_d;
    logic                  delay_active_q, delay_active_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        delay_s_d = delay_s_q;
        width_s_d = width_s_q;
        gap_s_d   = gap_s_q;
        last_s_d  = last_s_q;

        if (abort) begin
            // pulse index is deliberately left alone for post-mortem reads
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_d   = S_ARMED;
                        delay_s_d = delay_cycles;
                        width_s_d = width_cycles;
                        gap_s_d   = gap_cycles;
                        last_s_d  = (pulse_count == '0) ? '0 : pulse_count - NP_ONE;
                        idx_d     = '0;
                        cnt_d     = '0;
                    end
                end
                S_ARMED: begin
                    if (trig_rise) begin
                        // DELAY spans exactly delay cycles; zero delay skips it
                        if (delay_s_q == '0) begin
                            state_d = S_PULSE;
                            cnt_d   = len_m1(width_s_q);
                        end else begin
                            state_d = S_DELAY;
                            cnt_d   = delay_s_q - CNT_ONE;
                        end
                    end
                end
                S_DELAY: begin
                    if (cnt_q == '0) begin
                        state_d = S_PULSE;
                        cnt_d   = len_m1(width_s_q);
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        if (idx_q == last_s_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_GAP;
                            cnt_d   = len_m1(gap_s_q);
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = S_PULSE;
                        idx_d   = idx_q + NP_ONE;
                        cnt_d   = len_m1(width_s_q);
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_DONE: begin
                    // wait for the trigger to drop so one edge gives one burst
                    if (!trig_sync && !arm) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // outputs decoded from the next state so they move with the state
        glitch_d       = (state_d == S_PULSE) ? GLITCH_ACTIVE : ~GLITCH_ACTIVE;
        armed_d        = (state_d == S_ARMED);
        delay_active_d = (state_d == S_DELAY);
        busy_d         = is_busy(state_d);
        done_d         = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            delay_s_q      <= '0;
            width_s_q      <= '0;
            gap_s_q        <= '0;
            last_s_q       <= '0;
            glitch_q       <= ~GLITCH_ACTIVE;
            armed_q        <= 1'b0;
            delay_active_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            delay_s_q      <= delay_s_d;
            width_s_q      <= width_s_d;
            gap_s_q        <= gap_s_d;
            last_s_q       <= last_s_d;
            glitch_q       <= glitch_d;
            armed_q        <= armed_d;
            delay_active_q <= delay_active_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign glitch       = glitch_q;
    assign armed        = armed_q;
    assign delay_active = delay_active_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pulse_idx    = idx_q;

endmodule

// File: tb/tb_glitch_burst_gen.sv
module tb_glitch_burst_gen;

    localparam int   CNT_W = 32;
    localparam int   NPW   = 8;
    localparam logic G_ON  = 1'b1;
    localparam logic G_OFF = 1'b0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             arm = 1'b0, abort = 1'b0, trigger = 1'b0;
    logic [CNT_W-1:0] delay_cycles = '0, width_cycles = '0, gap_cycles = '0;
    logic [NPW-1:0]   pulse_count = '0;
    logic             glitch, armed, delay_active, busy, done;
    logic [NPW-1:0]   pulse_idx;

    int chk  = 0;
    int pass = 0;

    glitch_burst_gen #(.CNT_W(CNT_W), .NPULSE_W(NPW), .SYNC_STAGES(2), .GLITCH_ACTIVE(G_ON)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trigger(trigger),
        .delay_cycles(delay_cycles), .width_cycles(width_cycles), .gap_cycles(gap_cycles),
        .pulse_count(pulse_count), .glitch(glitch), .armed(armed), .delay_active(delay_active),
        .busy(busy), .done(done), .pulse_idx(pulse_idx)
    );

    always #5 clk = ~clk;

    // {glitch, armed, delay_active, busy, done, pulse_idx}
    function automatic logic [12:0] obs();
        return {glitch, armed, delay_active, busy, done, pulse_idx};
    endfunction

    // Expected outputs in cycle E+t (t>=1) from the timing rules:
    // delay d cycles, then n pulses of w cycles with g-cycle gaps, then DONE.
    function automatic logic [12:0] model(int t, int d, int w, int g, int n);
        int s, p, tot, i, r;
        s   = t - 1 - d;
        p   = w + g;
        tot = n * w + (n - 1) * g;
        if (s < 0)         return {G_OFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        else if (s >= tot) return {G_OFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'(n - 1)};
        i = s / p;
        r = s % p;
        return {(r < w) ? G_ON : G_OFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'(i)};
    endfunction

    task automatic arm_cfg(input logic [31:0] d, w, g, input logic [7:0] n);
        @(negedge clk);
        delay_cycles = d; width_cycles = w; gap_cycles = g; pulse_count = n;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk++;
        if (armed !== 1'b1 || busy !== 1'b0 || glitch !== G_OFF)
            $display("FAIL arm: armed=%b busy=%b glitch=%b, want 1 0 %b", armed, busy, glitch, G_OFF);
        else pass++;
    endtask

    // Raise trigger and compare every cycle through the first DONE cycle,
    // then drop trigger and confirm the return to IDLE.
    task automatic fire_check(input string nm, input int d, w, g, n);
        int we, ge, ne, last, t;
        logic [12:0] e;
        we = (w == 0) ? 1 : w;
        ge = (g == 0) ? 1 : g;
        ne = (n == 0) ? 1 : n;
        last = 1 + d + ne * we + (ne - 1) * ge;
        #($urandom_range(0, 3));
        trigger = 1'b1;
        for (int k = 1; k <= last + 2; k++) begin
            @(negedge clk);
            t = k - 2;
            chk++;
            if (t < 1) begin
                if (armed !== 1'b1 || glitch !== G_OFF)
                    $display("FAIL %s pre-edge k=%0d: armed=%b glitch=%b, want armed=1 idle", nm, k, armed, glitch);
                else pass++;
            end else begin
                e = model(t, d, we, ge, ne);
                if (obs() !== e)
                    $display("FAIL %s t=%0d: got %b, want %b", nm, t, obs(), e);
                else pass++;
            end
        end
        trigger = 1'b0;
        repeat (4) @(negedge clk);
        chk++;
        if ({glitch, armed, busy, done} !== {G_OFF, 3'b000})
            $display("FAIL %s idle-after: got %b, want %b", nm, {glitch, armed, busy, done}, {G_OFF, 3'b000});
        else pass++;
    endtask

    task automatic test_reset();
        #12;
        chk++;
        if (obs() !== {G_OFF, 12'd0}) $display("FAIL reset-held: got %b, want %b", obs(), {G_OFF, 12'd0});
        else pass++;
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk++;
        if (obs() !== {G_OFF, 12'd0}) $display("FAIL reset-release: got %b, want %b", obs(), {G_OFF, 12'd0});
        else pass++;
    endtask

    task automatic test_single();
        arm_cfg(10, 3, 0, 1);
        fire_check("single", 10, 3, 0, 1);
    endtask

    task automatic test_burst();
        arm_cfg(0, 2, 4, 3);
        fire_check("burst", 0, 2, 4, 3);
    endtask

    task automatic test_zero_cfg();
        arm_cfg(5, 0, 0, 0);
        fire_check("zero", 5, 0, 0, 0);
    endtask

    task automatic test_random();
        int d, w, g, n;
        for (int it = 0; it < 8; it++) begin
            d = $urandom_range(0, 12); w = $urandom_range(0, 4);
            g = $urandom_range(0, 4);  n = $urandom_range(0, 4);
            arm_cfg(d, w, g, n[7:0]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            fire_check("random", d, w, g, n);
        end
    endtask

    task automatic test_robust();
        int bad;
        trigger = 1'b1;
        repeat (4) @(negedge clk);
        arm_cfg(4, 2, 1, 2);
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (armed !== 1'b1 || glitch !== G_OFF) bad++;
        end
        chk++;
        if (bad != 0) $display("FAIL held-trigger: %0d bad cycles, want 0", bad);
        else pass++;
        trigger = 1'b0;
        delay_cycles = 9;  // must not affect the armed burst
        repeat (3) @(negedge clk);
        fire_check("robust", 4, 2, 1, 2);
    endtask

    task automatic test_abort();
        int bad;
        arm_cfg(1, 2, 3, 5);
        trigger = 1'b1;
        // 2nd pulse starts at E+1+d+(w+g) = E+7, sample index k = t+2
        repeat (9) @(negedge clk);
        chk++;
        if (glitch !== G_ON || pulse_idx !== 8'd1)
            $display("FAIL abort-pre: glitch=%b idx=%0d, want %b 1", glitch, pulse_idx, G_ON);
        else pass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk++;
        if (obs() !== {G_OFF, 4'b0000, 8'd1}) $display("FAIL abort: got %b, want %b", obs(), {G_OFF, 4'b0000, 8'd1});
        else pass++;
        trigger = 1'b0;
        repeat (3) @(negedge clk);
        trigger = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (glitch !== G_OFF || busy !== 1'b0 || armed !== 1'b0) bad++;
        end
        chk++;
        if (bad != 0) $display("FAIL abort-noretrig: %0d bad cycles, want 0", bad);
        else pass++;
        trigger = 1'b0;
        @(negedge clk);
        arm = 1'b1; abort = 1'b1;
        @(negedge clk);
        arm = 1'b0; abort = 1'b0;
        chk++;
        if (armed !== 1'b0 || pulse_idx !== 8'd1) $display("FAIL abort-beats-arm: armed=%b idx=%0d, want 0 1", armed, pulse_idx);
        else pass++;
    endtask

    task automatic test_max_delay();
        int bad;
        arm_cfg(32'hFFFF_FFFF, 1, 1, 1);
        trigger = 1'b1;
        repeat (3) @(negedge clk);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (delay_active !== 1'b1 || glitch !== G_OFF) bad++;
        end
        chk++;
        if (bad != 0) $display("FAIL max-delay: %0d bad cycles, want 0", bad);
        else pass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        trigger = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic async_reset_mid(input string nm, input logic [31:0] d, w, input bit want_pulse);
        int waited;
        arm_cfg(d, w, 1, 1);
        trigger = 1'b1;
        waited = 0;
        while ((want_pulse ? glitch !== G_ON : delay_active !== 1'b1) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk++;
        if (waited >= 20) $display("FAIL %s reach: timed out after %0d cycles, want < 20", nm, waited);
        else pass++;
        if (!want_pulse) repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk++;
        if (obs() !== {G_OFF, 12'd0}) $display("FAIL %s in-reset: got %b, want %b", nm, obs(), {G_OFF, 12'd0});
        else pass++;
        trigger = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk++;
        if (obs() !== {G_OFF, 12'd0}) $display("FAIL %s post-reset: got %b, want %b", nm, obs(), {G_OFF, 12'd0});
        else pass++;
    endtask

    task automatic test_async_reset();
        async_reset_mid("rst-delay", 20, 3, 1'b0);
        async_reset_mid("rst-pulse", 2, 8, 1'b1);
    endtask

    task automatic test_short_trigger();
        int ones;
        arm_cfg(3, 2, 1, 1);
        @(negedge clk);
        #1 trigger = 1'b1;
        #3 trigger = 1'b0;
        ones = 0;
        repeat (20) begin
            @(negedge clk);
            if (glitch === G_ON) ones++;
        end
        chk++;
        if (ones != 0 && ones != 2) $display("FAIL short-trigger: %0d glitch cycles, want 0 or 2", ones);
        else pass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_zero_cfg();
        test_random();
        test_robust();
        test_abort();
        test_max_delay();
        test_async_reset();
        test_short_trigger();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
